// File: rtl/dcache_pkg.sv
// Shared D-cache geometry constants and refill FSM encodings, also used by the lookup side.
// Write-back encodings exist only when DCACHE_WRITEBACK_EN is defined.
package dcache_pkg;

    localparam int ADDR_W      = 4;
    localparam int TAG_W       = 25;
    localparam int WAYS        = 2;
    localparam int LINE_WORDS  = 2;
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = WORD_BITS + 2;
    localparam int INDEX_LSB   = OFFSET_BITS;
    localparam int TAG_LSB     = INDEX_LSB + ADDR_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
`ifdef DCACHE_WRITEBACK_EN
    localparam logic [2:0] S_WB_ADDR = 3'd1;
    localparam logic [2:0] S_WB_DATA = 3'd2;
`endif
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_FILL    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    function automatic logic [WAYS-1:0] wayOneHot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU bit array for the 2-way D-cache; a set bit names the least-recently-used way.
module dcache_lru #(
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hitValid,
    input  logic                  hitWay,
    input  logic [addr_width-1:0] hitIndex,
    input  logic                  fillEn,
    input  logic                  fillWay,
    input  logic [addr_width-1:0] fillIndex,
    input  logic [addr_width-1:0] lookupIndex,
    output logic                  victim
);

    localparam int SETS = 1 << addr_width;

    logic [SETS-1:0] lruBits;

    // An install outranks a concurrent hit on the same set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lruBits <= '0;
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if (fillEn && fillIndex == addr_width'(s))
                    lruBits[s] <= ~fillWay;
                else if (hitValid && hitIndex == addr_width'(s))
                    lruBits[s] <= ~hitWay;
            end
        end
    end

    assign victim = lruBits[lookupIndex];

endmodule

// File: rtl/dcache_refill_ctrl.sv
// D-cache miss refill controller: victim selection, optional writeback, line fetch, tag install.
// DCACHE_WRITEBACK_EN enables dirty-victim writeback; otherwise write-through with wr_*/drd_* tied low.
module dcache_refill_ctrl
    import dcache_pkg::*;
#(
    parameter int addr_width = ADDR_W,
    parameter int data_width = TAG_W,
    parameter int way        = WAYS,
    parameter int line_words = LINE_WORDS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   miss_valid,
    output logic                                   miss_ready,
    input  logic [31:0]                            miss_addr,
    input  logic [way-1:0]                         miss_dirty,
    input  logic [way*data_width-1:0]              miss_vtag,
    input  logic                                   hit_valid,
    input  logic                                   hit_way,
    input  logic [addr_width-1:0]                  hit_index,
    output logic                                   drd_en,
    output logic [addr_width+$clog2(line_words)-1:0] drd_addr,
    output logic                                   drd_way,
    input  logic [31:0]                            drd_data,
    output logic                                   rd_req,
    output logic [31:0]                            rd_addr,
    input  logic                                   rd_ready,
    input  logic                                   ret_valid,
    input  logic [31:0]                            ret_data,
    input  logic                                   ret_last,
    output logic                                   wr_req,
    output logic [31:0]                            wr_addr,
    input  logic                                   wr_ready,
    output logic                                   wr_dvalid,
    output logic [31:0]                            wr_data,
    output logic                                   wr_last,
    input  logic                                   wr_dready,
    output logic [way-1:0]                         dwe,
    output logic [addr_width+$clog2(line_words)-1:0] dwaddr,
    output logic [31:0]                            dwdata,
    output logic [way-1:0]                         TagV_we,
    output logic [addr_width-1:0]                  TagV_addr_write,
    output logic [data_width-1:0]                  TagV_din_write,
    output logic [way-1:0]                         dirty_clr,
    output logic                                   refill_done
);

    localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    logic [2:0]            state;
    logic [addr_width-1:0] indexQ;
    logic [data_width-1:0] tagQ;
    logic                  victimQ;
    logic [WORD_BITS-1:0]  wordCnt;
    logic [addr_width-1:0] missIndex;
    logic                  lruVictim;
    logic                  fillNow;
    logic                  unusedAddr;

    assign missIndex  = miss_addr[INDEX_LSB +: addr_width];
    assign fillNow    = (state == S_FILL);
    assign unusedAddr = ^miss_addr[OFFSET_BITS-1:0];

    dcache_lru #(.addr_width(addr_width)) uLru (
        .clk        (clk),
        .rst        (rst),
        .hitValid   (hit_valid),
        .hitWay     (hit_way),
        .hitIndex   (hit_index),
        .fillEn     (fillNow),
        .fillWay    (victimQ),
        .fillIndex  (indexQ),
        .lookupIndex(missIndex),
        .victim     (lruVictim)
    );

`ifdef DCACHE_WRITEBACK_EN
    logic [data_width-1:0] victimTagQ;
    logic                  drdPend;
    logic                  wbValid;
    logic [31:0]           wbBuf;
    logic                  drdEn;

    // One data-array read per beat; the beat is buffered so wr_data holds steady under backpressure.
    assign drdEn = (state == S_WB_DATA) && !drdPend && !wbValid;
`else
    logic unusedWb;
    assign unusedWb = ^{miss_dirty, miss_vtag, drd_data, wr_ready, wr_dready};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            indexQ     <= '0;
            tagQ       <= '0;
            victimQ    <= 1'b0;
            wordCnt    <= '0;
`ifdef DCACHE_WRITEBACK_EN
            victimTagQ <= '0;
            drdPend    <= 1'b0;
            wbValid    <= 1'b0;
            wbBuf      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (miss_valid) begin
                        indexQ  <= missIndex;
                        tagQ    <= miss_addr[TAG_LSB +: data_width];
                        victimQ <= lruVictim;
                        wordCnt <= '0;
`ifdef DCACHE_WRITEBACK_EN
                        victimTagQ <= lruVictim ? miss_vtag[2*data_width-1:data_width]
                                                : miss_vtag[data_width-1:0];
                        drdPend    <= 1'b0;
                        wbValid    <= 1'b0;
                        state      <= miss_dirty[lruVictim] ? S_WB_ADDR : S_RD_ADDR;
`else
                        state   <= S_RD_ADDR;
`endif
                    end
                end
`ifdef DCACHE_WRITEBACK_EN
                S_WB_ADDR: begin
                    if (wr_ready)
                        state <= S_WB_DATA;
                end
                S_WB_DATA: begin
                    drdPend <= drdEn;
                    if (drdPend) begin
                        wbBuf   <= drd_data;
                        wbValid <= 1'b1;
                    end else if (wbValid && wr_dready) begin
                        wbValid <= 1'b0;
                        wordCnt <= wordCnt + WORD_BITS'(1);
                        if (wordCnt == LAST_WORD)
                            state <= S_RD_ADDR;
                    end
                end
`endif
                S_RD_ADDR: begin
                    if (rd_ready)
                        state <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (ret_valid) begin
                        wordCnt <= wordCnt + WORD_BITS'(1);
                        if (ret_last || wordCnt == LAST_WORD)
                            state <= S_FILL;
                    end
                end
                S_FILL:  state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready = (state == S_IDLE);
    assign rd_req     = (state == S_RD_ADDR);
    assign rd_addr    = {tagQ, indexQ, {OFFSET_BITS{1'b0}}};

    assign dwe    = (state == S_RD_DATA && ret_valid) ? wayOneHot(victimQ) : '0;
    assign dwaddr = {indexQ, wordCnt};
    assign dwdata = (state == S_RD_DATA) ? ret_data : '0;

    // Tag/valid goes in only after every data word has been written.
    assign TagV_we         = fillNow ? wayOneHot(victimQ) : '0;
    assign dirty_clr       = fillNow ? wayOneHot(victimQ) : '0;
    assign TagV_addr_write = indexQ;
    assign TagV_din_write  = tagQ;
    assign refill_done     = (state == S_DONE);

`ifdef DCACHE_WRITEBACK_EN
    assign wr_req    = (state == S_WB_ADDR);
    assign wr_addr   = {victimTagQ, indexQ, {OFFSET_BITS{1'b0}}};
    assign wr_dvalid = wbValid;
    assign wr_data   = wbBuf;
    assign wr_last   = wbValid && (wordCnt == LAST_WORD);
    assign drd_en    = drdEn;
    assign drd_addr  = {indexQ, wordCnt};
    assign drd_way   = drdEn & victimQ;
`else
    assign wr_req    = 1'b0;
    assign wr_addr   = '0;
    assign wr_dvalid = 1'b0;
    assign wr_data   = '0;
    assign wr_last   = 1'b0;
    assign drd_en    = 1'b0;
    assign drd_addr  = '0;
    assign drd_way   = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl; writeback steps run only when DCACHE_WRITEBACK_EN is defined.
module tb_dcache_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid, miss_ready;
    logic [31:0] miss_addr;
    logic [1:0]  miss_dirty;
    logic [49:0] miss_vtag;
    logic        hit_valid, hit_way;
    logic [3:0]  hit_index;
    logic        drd_en, drd_way;
    logic [4:0]  drd_addr;
    logic [31:0] drd_data;
    logic        rd_req, rd_ready, ret_valid, ret_last;
    logic [31:0] rd_addr, ret_data;
    logic        wr_req, wr_ready, wr_dvalid, wr_last, wr_dready;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  dwe, TagV_we, dirty_clr;
    logic [4:0]  dwaddr;
    logic [31:0] dwdata;
    logic [3:0]  TagV_addr_write;
    logic [24:0] TagV_din_write;
    logic        refill_done;

    int total = 0;
    int bad   = 0;
    int cycNo = 0;
    int doneCyc = 0;

    always #5 clk = ~clk;

    dcache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_dirty(miss_dirty), .miss_vtag(miss_vtag),
        .hit_valid(hit_valid), .hit_way(hit_way), .hit_index(hit_index),
        .drd_en(drd_en), .drd_addr(drd_addr), .drd_way(drd_way), .drd_data(drd_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .ret_valid(ret_valid), .ret_data(ret_data), .ret_last(ret_last),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .wr_dvalid(wr_dvalid), .wr_data(wr_data), .wr_last(wr_last), .wr_dready(wr_dready),
        .dwe(dwe), .dwaddr(dwaddr), .dwdata(dwdata),
        .TagV_we(TagV_we), .TagV_addr_write(TagV_addr_write), .TagV_din_write(TagV_din_write),
        .dirty_clr(dirty_clr), .refill_done(refill_done)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        cycNo++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        total++;
        assert (obs === want)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic acceptMiss(input logic [31:0] a, input logic [1:0] d, input logic [49:0] vt);
        miss_valid = 1'b1;
        miss_addr  = a;
        miss_dirty = d;
        miss_vtag  = vt;
        #1;
        chk("miss_ready_accept", miss_ready, 1);
        cycNo = 1;
        cyc();
        miss_valid = 1'b0;
    endtask

    // Clean read with a memory that accepts and returns immediately, then FILL/DONE checks.
    task automatic readFill(input logic [3:0] idx, input logic [24:0] tag, input logic wy,
                            input bit hitInFill);
        logic [1:0] oh;
        oh = wy ? 2'b10 : 2'b01;
        rd_ready  = 1'b1;
        ret_valid = 1'b1;
        ret_last  = 1'b0;
        #1;
        chk("rd_req", rd_req, 1);
        chk("rd_addr", rd_addr, {tag, idx, 3'b000});
        chk("wr_req_in_read", wr_req, 0);
        cyc();
        for (int w = 0; w < 2; w++) begin
            ret_data = 32'hCAFE_0000 + w;
            ret_last = (w == 1);
            #1;
            chk("dwe", dwe, oh);
            chk("dwaddr", dwaddr, {idx, w[0]});
            chk("dwdata", dwdata, 32'hCAFE_0000 + w);
            chk("tagv_early", TagV_we, 0);
            cyc();
        end
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        rd_ready  = 1'b0;
        if (hitInFill) begin
            hit_valid = 1'b1;
            hit_way   = 1'b0;
            hit_index = idx;
        end
        #1;
        chk("tagv_we", TagV_we, oh);
        chk("tagv_addr", TagV_addr_write, idx);
        chk("tagv_din", TagV_din_write, tag);
        chk("dirty_clr", dirty_clr, oh);
        chk("done_early", refill_done, 0);
        cyc();
        hit_valid = 1'b0;
        #1;
        chk("refill_done", refill_done, 1);
        chk("tagv_after_fill", TagV_we, 0);
        doneCyc = cycNo;
        cyc();
        chk("idle_ready", miss_ready, 1);
        chk("done_pulse_end", refill_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        miss_valid = 0; miss_addr = 0; miss_dirty = 0; miss_vtag = 0;
        hit_valid = 0; hit_way = 0; hit_index = 0;
        drd_data = 0; rd_ready = 0; ret_valid = 0; ret_data = 0; ret_last = 0;
        wr_ready = 0; wr_dready = 0;
        cyc();
        cyc();
        chk("rst_miss_ready", miss_ready, 1);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_dwe", dwe, 0);
        chk("rst_tagv_we", TagV_we, 0);
        chk("rst_dirty_clr", dirty_clr, 0);
        chk("rst_refill_done", refill_done, 0);
        chk("rst_drd_en", drd_en, 0);
        rst = 1'b0;
        cyc();

        // Clean miss 0x1230: set 6, tag 0x24, LRU 0 -> way 0; done in the 6th cycle counting accept as 1.
        acceptMiss(32'h0000_1230, 2'b00, 50'h0);
        readFill(4'h6, 25'h24, 1'b0, 1'b0);
        chk("latency", doneCyc, 6);

`ifdef DCACHE_WRITEBACK_EN
        // Dirty way 1 (tag 0x5) in set 6, LRU now 1: writeback to 0x2B0 then fetch 0x1830.
        acceptMiss(32'h0000_1830, 2'b10, {25'h5, 25'h1});
        wr_ready = 1'b1;
        #1;
        chk("wr_req", wr_req, 1);
        chk("wr_addr", wr_addr, 32'h0000_02B0);
        chk("rd_req_in_wb", rd_req, 0);
        cyc();
        wr_ready = 1'b0;
        #1;
        chk("drd_en_b0", drd_en, 1);
        chk("drd_addr_b0", drd_addr, 5'h0C);
        chk("drd_way_b0", drd_way, 1);
        chk("wr_dvalid_pre", wr_dvalid, 0);
        cyc();
        drd_data = 32'hD0D0_0000;
        #1;
        chk("drd_en_gap", drd_en, 0);
        cyc();
        drd_data = 32'h1111_1111;
        #1;
        chk("wr_dvalid_b0", wr_dvalid, 1);
        chk("wr_data_b0", wr_data, 32'hD0D0_0000);
        chk("wr_last_b0", wr_last, 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("stall_dvalid", wr_dvalid, 1);
            chk("stall_data", wr_data, 32'hD0D0_0000);
            chk("stall_drd_en", drd_en, 0);
        end
        cyc();
        wr_dready = 1'b1;
        #1;
        chk("b0_held", wr_data, 32'hD0D0_0000);
        cyc();
        wr_dready = 1'b0;
        #1;
        chk("b0_not_repeated", wr_dvalid, 0);
        chk("drd_en_b1", drd_en, 1);
        chk("drd_addr_b1", drd_addr, 5'h0D);
        cyc();
        drd_data = 32'hD0D0_0001;
        #1;
        cyc();
        wr_dready = 1'b1;
        #1;
        chk("wr_dvalid_b1", wr_dvalid, 1);
        chk("wr_data_b1", wr_data, 32'hD0D0_0001);
        chk("wr_last_b1", wr_last, 1);
        cyc();
        wr_dready = 1'b0;
        readFill(4'h6, 25'h30, 1'b1, 1'b0);
`else
        // Write-through: dirty bits ignored, victim way 1 of set 6 fetched directly.
        acceptMiss(32'h0000_1830, 2'b11, {25'h5, 25'h1});
        chk("wt_drd_en", drd_en, 0);
        chk("wt_wr_dvalid", wr_dvalid, 0);
        readFill(4'h6, 25'h30, 1'b1, 1'b0);
`endif

        // Hit on way 0 of set 3 makes way 1 the victim; a hit during FILL loses to the fill.
        hit_valid = 1'b1;
        hit_way   = 1'b0;
        hit_index = 4'h3;
        cyc();
        hit_valid = 1'b0;
        acceptMiss(32'h0000_0898, 2'b00, 50'h0);
        readFill(4'h3, 25'h11, 1'b1, 1'b1);
        acceptMiss(32'h0000_0918, 2'b00, 50'h0);
        readFill(4'h3, 25'h12, 1'b0, 1'b0);

        // ret_last on the first beat ends the fetch; a stray beat afterwards is ignored.
        acceptMiss(32'h0000_0190, 2'b00, 50'h0);
        rd_ready = 1'b1;
        cyc();
        rd_ready  = 1'b0;
        ret_valid = 1'b1;
        ret_last  = 1'b1;
        #1;
        chk("early_dwe", dwe, 2'b01);
        chk("early_dwaddr", dwaddr, 5'h04);
        cyc();
        ret_last = 1'b0;
        #1;
        chk("early_fill", TagV_we, 2'b01);
        chk("early_stray_dwe", dwe, 0);
        cyc();
        ret_valid = 1'b0;
        chk("early_done", refill_done, 1);
        cyc();

        // Reset in RD_DATA after one beat: back to IDLE, nothing installed.
        acceptMiss(32'h0000_03A8, 2'b00, 50'h0);
        rd_ready = 1'b1;
        cyc();
        rd_ready  = 1'b0;
        ret_valid = 1'b1;
        ret_data  = 32'h5555_0000;
        #1;
        chk("mid_dwe", dwe, 2'b01);
        chk("mid_dwaddr", dwaddr, 5'h0A);
        cyc();
        rst = 1'b1;
        #1;
        chk("async_rst_ready", miss_ready, 1);
        chk("async_rst_dwe", dwe, 0);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_tagv", TagV_we, 0);
            chk("post_rst_ready", miss_ready, 1);
            chk("post_rst_done", refill_done, 0);
            cyc();
        end
        ret_valid = 1'b0;

        // Reset cleared LRU: set 3 (LRU was 1) now victimises way 0.
        acceptMiss(32'h0000_0998, 2'b00, 50'h0);
        readFill(4'h3, 25'h13, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
